// File: rtl/fir_s25_pkg.sv
// fir_s25_pkg: shared widths, coefficient set and saturation for the 33-tap FIR.
package fir_s25_pkg;

    localparam int DATA_W = 24;
    localparam int COEF_W = 16;
    localparam int TAPS   = 33;
    localparam int FRAC   = 15;
    localparam int ACC_W  = 46;

    // Symmetric Q1.15 low-pass set; the taps sum to exactly 32768 (unity DC gain).
    localparam logic signed [COEF_W-1:0] COEF [TAPS] = '{
        -16'sd30,  -16'sd45,  -16'sd50,  -16'sd30,  16'sd20,   16'sd100,  16'sd200,  16'sd320,
        16'sd480,  16'sd700,  16'sd950,  16'sd1200, 16'sd1450, 16'sd1700, 16'sd1900, 16'sd2050,
        16'sd10938,
        16'sd2050, 16'sd1900, 16'sd1700, 16'sd1450, 16'sd1200, 16'sd950,  16'sd700,  16'sd480,
        16'sd320,  16'sd200,  16'sd100,  16'sd20,   -16'sd30,  -16'sd50,  -16'sd45,  -16'sd30
    };

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    function automatic logic signed [DATA_W-1:0] sat24(input logic signed [ACC_W-1:0] v);
        return v > SAT_MAX ? DATA_W'(SAT_MAX) : v < SAT_MIN ? DATA_W'(SAT_MIN) : DATA_W'(v);
    endfunction

endpackage

// File: rtl/fir_s25_channel.sv
// fir_s25_channel: one channel's delay line, MAC, round-half-up, saturate and output register.
import fir_s25_pkg::*;

module fir_s25_channel (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout
);

    logic signed [DATA_W-1:0] taps [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  rnd;

    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(taps[k]) * ACC_W'(COEF[k]);
        rnd = (acc + HALF) >>> FRAC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) taps[k] <= '0;
            dout <= '0;
        end else begin
            taps[0] <= din;
            for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
            dout <= sat24(rnd);
        end
    end

endmodule

// File: rtl/fir_filter_s25.sv
// fir_filter_s25: three lock-step channels of the 33-tap low-pass FIR sharing one coefficient set.
import fir_s25_pkg::*;

module fir_filter_s25 (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inputData1,
    input  logic [DATA_W-1:0] inputData2,
    input  logic [DATA_W-1:0] inputData3,
    output logic [DATA_W-1:0] outputData1,
    output logic [DATA_W-1:0] outputData2,
    output logic [DATA_W-1:0] outputData3
);

    fir_s25_channel ch1 (.clk(clk), .reset(reset), .din(inputData1), .dout(outputData1));
    fir_s25_channel ch2 (.clk(clk), .reset(reset), .din(inputData2), .dout(outputData2));
    fir_s25_channel ch3 (.clk(clk), .reset(reset), .din(inputData3), .dout(outputData3));

endmodule

// File: tb/tb_fir_filter_s25.sv
// tb_fir_filter_s25: randomized and directed checks of the three-channel FIR against a dot-product model.
module tb_fir_filter_s25;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] in1 = '0, in2 = '0, in3 = '0;
    logic [23:0] o1, o2, o3;
    int          vectors = 0;
    int          miscompares = 0;

    localparam longint C [33] = '{
        -30, -45, -50, -30, 20, 100, 200, 320, 480, 700, 950, 1200, 1450, 1700, 1900, 2050,
        10938,
        2050, 1900, 1700, 1450, 1200, 950, 700, 480, 320, 200, 100, 20, -30, -50, -45, -30
    };

    // hist[ch][k] is the sample taken k+1 edges before the next output edge
    longint hist [3][33];
    longint expv [3];

    always #5 clk = ~clk;

    fir_filter_s25 dut (
        .clk(clk), .reset(reset),
        .inputData1(in1), .inputData2(in2), .inputData3(in3),
        .outputData1(o1), .outputData2(o2), .outputData3(o3)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [23:0] v);
        return longint'(signed'(v));
    endfunction

    function automatic longint sat(input longint v);
        return v > 8388607 ? 64'sd8388607 : v < -8388608 ? -64'sd8388608 : v;
    endfunction

    function automatic longint rnd_sample();
        return $urandom_range(0, 3) == 0 ? sx(24'($urandom)) : longint'($urandom_range(0, 4000)) - 2000;
    endfunction

    task automatic model_edge();
        longint x [3];
        longint acc;
        x = '{sx(in1), sx(in2), sx(in3)};
        for (int ch = 0; ch < 3; ch++) begin
            if (reset) begin
                for (int k = 0; k < 33; k++) hist[ch][k] = 0;
                expv[ch] = 0;
            end else begin
                acc = 0;
                for (int k = 0; k < 33; k++) acc += C[k] * hist[ch][k];
                expv[ch] = sat((acc + 16384) >>> 15);
                for (int k = 32; k > 0; k--) hist[ch][k] = hist[ch][k-1];
                hist[ch][0] = x[ch];
            end
        end
    endtask

    task automatic cycle(input longint a, input longint b, input longint c);
        in1 = 24'(a);
        in2 = 24'(b);
        in3 = 24'(c);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("out1", sx(o1), expv[0]);
        check("out2", sx(o2), expv[1]);
        check("out3", sx(o3), expv[2]);
    endtask

    initial begin
        repeat (3) cycle($urandom_range(1, 8388607), $urandom_range(1, 8388607), $urandom_range(1, 8388607));
        check("rst_hold", sx(o1) | sx(o2) | sx(o3), 0);
        reset = 1'b0;
        repeat (33) cycle(0, 0, 0);
        cycle(32768, 0, 0);
        for (int k = 0; k < 33; k++) begin
            cycle(0, 0, 0);
            check("impulse1", sx(o1), C[k]);
            check("impulse_leak", sx(o2) | sx(o3), 0);
        end
        cycle(0, 0, 0);
        check("impulse_tail", sx(o1), 0);
        repeat (40) cycle(1, 1, 1);
        check("step1", sx(o1), 1);
        check("step3", sx(o3), 1);
        repeat (40) cycle(1000, -1000, 8388607);
        check("dc1", sx(o1), 1000);
        check("dc2", sx(o2), -1000);
        check("dc3", sx(o3), 8388607);
        for (int j = 0; j < 33; j++) cycle(C[j] > 0 ? 8388607 : -8388608, 0, 0);
        cycle(0, 0, 0);
        check("sat_pos", sx(o1), 8388607);
        for (int j = 0; j < 33; j++) cycle(C[j] > 0 ? -8388608 : 8388607, 0, 0);
        cycle(0, 0, 0);
        check("sat_neg", sx(o1), -8388608);
        repeat (33) cycle(0, 0, 0);
        cycle(32768, 0, 0);
        cycle(0, 32768, 0);
        cycle(0, 0, 32768);
        for (int k = 0; k < 31; k++) begin
            cycle(0, 0, 0);
            check("stagger1", sx(o1), C[k + 2]);
            check("stagger2", sx(o2), C[k + 1]);
            check("stagger3", sx(o3), C[k]);
        end
        repeat (5) cycle(0, 0, 0);
        repeat (300) cycle(rnd_sample(), rnd_sample(), rnd_sample());
        #2 reset = 1'b1;
        #1;
        model_edge();
        check("arst1", sx(o1), 0);
        check("arst2", sx(o2), 0);
        check("arst3", sx(o3), 0);
        cycle(rnd_sample(), rnd_sample(), rnd_sample());
        reset = 1'b0;
        repeat (33) cycle(0, 0, 0);
        repeat (60) cycle(rnd_sample(), rnd_sample(), rnd_sample());
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_filter_s25.md
Name: fir_filter_s25

Overview:
- Three-channel, 33-tap, fixed-coefficient low-pass FIR filter for 24-bit signed samples.
- All three channels share one coefficient set and run in lock-step, one new sample per channel on every clock.
- Sits in the sample datapath between the input sample source and downstream processing.
- No valid/ready handshake: every clock edge is a sample.

Parameters:
- DATA_W, 24, sample width in and out (signed two's complement).
- COEF_W, 16, coefficient width (signed Q1.15).
- TAPS, 33, number of filter taps.
- FRAC, 15, fractional bits removed from the accumulator before output.

Ports:
- clk  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-high reset.
- inputData1  in  24  channel 1 input sample, signed.
- inputData2  in  24  channel 2 input sample, signed.
- inputData3  in  24  channel 3 input sample, signed.
- outputData1  out  24  channel 1 filtered sample, signed, registered.
- outputData2  out  24  channel 2 filtered sample, signed, registered.
- outputData3  out  24  channel 3 filtered sample, signed, registered.

Behaviour:
- Reset (asynchronous, active-high): immediately clears all 33 delay-line registers and all three output registers to 0, in every channel. It takes effect even mid-stream. The first edge after deassertion samples normally.
- Delay line, per channel, on each rising edge: tap[0] <= inputData; tap[k] <= tap[k-1] for k = 1..32.
- Output, per channel, on the same edge: out <= sat24((acc + 2^14) >>> 15), where acc = sum over k = 0..32 of COEF[k]*tap[k].
  - acc is computed from the pre-edge taps.
  - acc is at least 46 bits signed (24 + 16 + 6 guard bits), so no intermediate overflow.
  - ">>>" is an arithmetic shift; adding 2^14 gives round-half-up.
- sat24: results above 8388607 clamp to 8388607; results below -8388608 clamp to -8388608.
- Latency: an input sample held before edge n is in tap[0] after edge n. Its first contribution, COEF[0]*x, appears on the output after edge n+1. Impulse response therefore spans output edges n+1 .. n+33.
- Coefficients:
  - Constant, symmetric: COEF[k] = COEF[32-k].
  - Sum of all COEF equals exactly 32768, i.e. DC gain of 1.0.
  - The set includes negative sidelobe values, so the sum of |COEF| exceeds 32768.
- Channels are fully independent: no cross-coupling of data.
- No enable; the filter runs every cycle.

Decomposition:
- Shared package fir_s25_pkg holds:
  - DATA_W, COEF_W, TAPS, FRAC, ACC_W (46).
  - The coefficient array COEF[0..32].
  - A saturation function sat24.
- One sub-module, fir_s25_channel: delay line, MAC, round, saturate and output register for one channel.
- The top instantiates fir_s25_channel three times.

Test Plan:
1. Reset behaviour:
   - Hold reset for 3 cycles with nonzero inputs -> all outputs 0.
   - Pulse reset mid-stream -> outputs 0 immediately, asynchronously.
   - After reset, with zero input, outputs stay 0 for 33 cycles (delay line cleared).
2. Impulse on channel 1:
   - Drive inputData1 = 32768 for one cycle, 0 otherwise -> outputData1 = COEF[0], COEF[1], ..., COEF[32] on 33 consecutive edges starting one edge after the sampling edge, then 0.
   - outputData2 and outputData3 remain 0.
3. Unit step, all channels: hold all inputs at 1 after reset -> outputs rise through partial sums and settle at exactly 1 from the 34th edge onward.
4. DC accuracy: hold inputData1 = 1000, inputData2 = -1000, inputData3 = 8388607 -> steady state 1000, -1000, 8388607 respectively.
5. Saturation: feed channel 1 with x[n-k] = +8388607 where COEF[k] > 0 and -8388608 where COEF[k] < 0 -> outputData1 = 8388607. Feed the negated pattern -> outputData1 = -8388608. No wrap-around.
6. Channel independence: staggered impulses on channels 1, 2, 3 one cycle apart -> each output shows its own coefficient sequence, offset by one cycle, with no leakage between channels.
